// File: rtl/serial_addsub_nand_if.sv
// Request/response bundle for the bit-serial adder/subtractor.
// The master drives the operands and start; the slave returns status and result.
interface serial_addsub_nand_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_nand.sv
// Bit-serial two's-complement add/subtract that reuses one NAND-only full adder,
// processing one bit pair per clock LSB first and holding the carry in a flop.
module serial_addsub_nand #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_addsub_nand_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;
  logic             last;

  logic fa_x, fa_y, fa_s, fa_c;
  logic n1, n2, n3, n4, n5, n6, n7;

  assign fa_x = op_a[0];
  assign fa_y = op_b[0];
  assign last = (cnt == LAST);

  // Nine-NAND full adder: n4 is x^y, the second half-adder folds in the carry.
  assign n1   = ~(fa_x & fa_y);
  assign n2   = ~(fa_x & n1);
  assign n3   = ~(fa_y & n1);
  assign n4   = ~(n2 & n3);
  assign n5   = ~(n4 & carry_q);
  assign n6   = ~(n4 & n5);
  assign n7   = ~(carry_q & n5);
  assign fa_s = ~(n6 & n7);
  assign fa_c = ~(n5 & n1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:                   state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      res_sh   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a    <= bus.a;
            op_b    <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          res_sh  <= {fa_s, res_sh[WIDTH-1:1]};
          op_a    <= {1'b0, op_a[WIDTH-1:1]};
          op_b    <= {1'b0, op_b[WIDTH-1:1]};
          carry_q <= fa_c;
          // Hold the counter on the MSB cycle so it never wraps.
          if (!last) cnt <= cnt + CW'(1);
          if (last) begin
            result_q <= {fa_s, res_sh[WIDTH-1:1]};
            cout_q   <= fa_c;
            ovf_q    <= carry_q ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
endmodule
